axi_slv_rd_engine: RTL and testbench

AXI_SLV_RD_ENGINE -- requirements
Module: axi_slv_rd_engine

---
 rtl/axi_slv_pkg.sv | 37 +++
 rtl/axi_sync_fifo.sv | 46 ++++
 rtl/axi_slv_rd_engine.sv | 186 ++++++++++++++++++
 tb/tb_axi_slv_rd_engine.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slv_pkg.sv
// Shared types for the AXI slave read engine.
// Burst/response encodings, engine states and the queued AR request.
package axi_slv_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DATA
  } eng_state_e;

  // ID and address ride alongside; their widths are per-instance.
  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    burst_e     burst;
  } ar_req_t;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return len inside {8'd1, 8'd3, 8'd7, 8'd15};
  endfunction

endpackage

// File: rtl/axi_sync_fifo.sv
// Synchronous FIFO with full/empty flags.
// Extra pointer bit distinguishes full from empty.
module axi_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] INC = (AW+1)'(1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full)
        wp <= wp + INC;
      if (pop && !empty)
        rp <= rp + INC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push && !full)
      mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/axi_slv_rd_engine.sv
// AXI slave read engine: queued AR requests, one beat
// per three cycles from a one-cycle-latency memory.
module axi_slv_rd_engine
  import axi_slv_pkg::*;
#(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int AR_DEPTH  = 4,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   ARID,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [7:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int QW = ID_W + ADDR_W + $bits(ar_req_t);
  localparam logic [2:0] BUS_SZ = 3'($clog2(DATA_W/8));
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] BUS_MASK =
    ADDR_W'(DATA_W/8 - 1);
  localparam logic [ADDR_W:0] MEM_LIM =
    (ADDR_W+1)'(MEM_BYTES);

  eng_state_e        state;
  logic              rdy_en;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [QW-1:0]     q_din;
  logic [QW-1:0]     q_dout;
  logic [ID_W-1:0]   h_id;
  logic [ADDR_W-1:0] h_addr;
  ar_req_t           h_req;
  logic              h_err;
  logic              h_oor;
  logic [ADDR_W-1:0] addr;
  ar_req_t           req;
  logic [7:0]        beat;
  logic              burst_err;
  logic              beat_err;
  logic [ADDR_W-1:0] n_addr;
  logic              n_oor;

  function automatic logic [ADDR_W-1:0] bsz(
    input logic [2:0] s
  );
    return ONE << s;
  endfunction

  // Widened by one bit so addresses near the top cannot alias low.
  function automatic logic oor(
    input logic [ADDR_W-1:0] a,
    input logic [2:0]        s
  );
    return ({1'b0, a} + {1'b0, bsz(s)}) > MEM_LIM;
  endfunction

  function automatic logic [ADDR_W-1:0] nxt_addr(
    input logic [ADDR_W-1:0] a,
    input ar_req_t           r
  );
    logic [ADDR_W-1:0] b;
    logic [ADDR_W-1:0] w;
    logic [ADDR_W-1:0] n;
    b = bsz(r.size);
    w = (ADDR_W'(r.len) + ONE) << r.size;
    unique case (r.burst)
      BURST_INCR: n = (a & ~(b - ONE)) + b;
      BURST_WRAP: n = (a & ~(w - ONE)) | ((a + b) & (w - ONE));
      default:    n = a;
    endcase
    return n;
  endfunction

  assign q_din   = {ARID, ARADDR, ARLEN, ARSIZE, ARBURST};
  assign {h_id, h_addr, h_req} = q_dout;
  assign ARREADY = rdy_en & ~full;
  assign push    = ARVALID & ARREADY;
  assign pop     = (state == S_IDLE) & ~empty;

  always_comb begin
    h_err = (h_req.size > BUS_SZ) ||
            (h_req.burst == BURST_RSVD) ||
            ((h_req.burst == BURST_WRAP) &&
             (!wrap_len_ok(h_req.len) ||
              ((h_addr & (bsz(h_req.size) - ONE)) != '0)));
  end

  assign h_oor  = oor(h_addr, h_req.size);
  assign n_addr = nxt_addr(addr, req);
  assign n_oor  = oor(n_addr, req.size);

  axi_sync_fifo #(
    .W     (QW),
    .DEPTH (AR_DEPTH)
  ) u_ar_q (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (q_din),
    .pop   (pop),
    .dout  (q_dout),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      rdy_en    <= 1'b0;
      RID       <= '0;
      RDATA     <= '0;
      RRESP     <= RESP_OKAY;
      RLAST     <= 1'b0;
      RVALID    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      addr      <= '0;
      req       <= '0;
      beat      <= '0;
      burst_err <= 1'b0;
      beat_err  <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      mem_re <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!empty) begin
            RID       <= h_id;
            addr      <= h_addr;
            req       <= h_req;
            beat      <= '0;
            burst_err <= h_err;
            beat_err  <= h_err | h_oor;
            mem_addr  <= h_addr & ~BUS_MASK;
            mem_re    <= ~(h_err | h_oor);
            state     <= S_REQ;
          end
        end
        S_REQ: state <= S_WAIT;
        S_WAIT: begin
          RVALID <= 1'b1;
          RLAST  <= (beat == req.len);
          RRESP  <= beat_err ? RESP_SLVERR : RESP_OKAY;
          RDATA  <= beat_err ? '0 : mem_rdata;
          state  <= S_DATA;
        end
        S_DATA: begin
          if (RREADY) begin
            RVALID <= 1'b0;
            RLAST  <= 1'b0;
            if (RLAST) begin
              state <= S_IDLE;
            end else begin
              addr     <= n_addr;
              beat     <= beat + 8'd1;
              beat_err <= burst_err | n_oor;
              mem_addr <= n_addr & ~BUS_MASK;
              mem_re   <= ~(burst_err | n_oor);
              state    <= S_REQ;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slv_rd_engine.sv
// Scoreboard bench for axi_slv_rd_engine: directed bursts,
// backpressure, errors, reset, then randomized traffic.
module tb_axi_slv_rd_engine;

  localparam int MEM_BYTES = 1024;
  localparam int DATA_W    = 32;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  ARID = '0;
  logic [31:0] ARADDR = '0;
  logic [7:0]  ARLEN = '0;
  logic [2:0]  ARSIZE = '0;
  logic [1:0]  ARBURST = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;

  logic rr_rand = 1'b0;
  logic rr_val  = 1'b0;
  logic rr_rnd  = 1'b0;
  assign RREADY = rr_rand ? rr_rnd : rr_val;

  beat_t       sb[$];
  logic [31:0] maq[$];
  int          pop_cyc[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;

  logic        stalled = 1'b0;
  logic [38:0] held = '0;

  axi_slv_rd_engine #(
    .ID_W      (4),
    .ADDR_W    (32),
    .DATA_W    (DATA_W),
    .AR_DEPTH  (4),
    .MEM_BYTES (MEM_BYTES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ARID      (ARID),
    .ARADDR    (ARADDR),
    .ARLEN     (ARLEN),
    .ARSIZE    (ARSIZE),
    .ARBURST   (ARBURST),
    .ARVALID   (ARVALID),
    .ARREADY   (ARREADY),
    .RID       (RID),
    .RDATA     (RDATA),
    .RRESP     (RRESP),
    .RLAST     (RLAST),
    .RVALID    (RVALID),
    .RREADY    (RREADY),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // Memory answers the cycle after mem_re; junk otherwise.
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    mem_rdata <= mem_re ? pat(mem_addr) : $urandom;
    rr_rnd    <= ($urandom_range(0, 3) != 0);
  end

  function automatic void check(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void flag(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected DUT activity at cycle %0d",
             nm, cyc);
  endfunction

  // Reference: expected beats from the AXI burst rules.
  function automatic void model_ar(
    input logic [3:0]  id,
    input logic [31:0] a0,
    input logic [7:0]  len,
    input logic [2:0]  sz,
    input logic [1:0]  bt
  );
    longint unsigned b  = 64'd1 << sz;
    longint unsigned w  = (longint'(len) + 1) * b;
    longint unsigned lo = (a0 / w) * w;
    bit bad = (bt == 2'd3) || (b > DATA_W / 8) ||
              ((bt == 2'd2) &&
               (!(len inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                (a0 % b) != 0));
    for (int i = 0; i <= int'(len); i++) begin
      logic [31:0] a;
      bit          err;
      beat_t       e;
      if (bt == 2'd0)
        a = a0;
      else if (bt == 2'd1)
        a = (i == 0) ? a0 : 32'((a0 / b) * b + i * b);
      else
        a = 32'(lo + (a0 - lo + i * b) % w);
      err    = bad || (longint'(a) + b > MEM_BYTES);
      e.id   = id;
      e.data = err ? 32'd0 : pat(a & ~32'h3);
      e.resp = err ? 2'd2 : 2'd0;
      e.last = (i == int'(len));
      sb.push_back(e);
      if (!err)
        maq.push_back(a & ~32'h3);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      stalled = 1'b0;
    end else begin
      if (mem_re) begin
        if (maq.size() == 0)
          flag("mem_re_spurious");
        else
          check("mem_addr", mem_addr, maq.pop_front());
      end
      if (RVALID && RREADY) begin
        if (sb.size() == 0) begin
          flag("rbeat_spurious");
        end else begin
          beat_t e;
          e = sb.pop_front();
          check("rid", RID, e.id);
          check("rdata", RDATA, e.data);
          check("rresp", RRESP, e.resp);
          check("rlast", RLAST, e.last);
          pop_cyc.push_back(cyc);
        end
      end
      if (RVALID && !RREADY) begin
        if (stalled)
          check("stall_hold", {RID, RDATA, RRESP, RLAST}, held);
        stalled = 1'b1;
        held    = {RID, RDATA, RRESP, RLAST};
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic send_ar(
    input  logic [3:0]  id,
    input  logic [31:0] a,
    input  logic [7:0]  len,
    input  logic [2:0]  sz,
    input  logic [1:0]  bt,
    input  int          maxc,
    output bit          acc
  );
    logic hs;
    ARID    = id;
    ARADDR  = a;
    ARLEN   = len;
    ARSIZE  = sz;
    ARBURST = bt;
    ARVALID = 1'b1;
    acc     = 1'b0;
    for (int k = 0; k < maxc && !acc; k++) begin
      @(negedge clk);
      hs = ARREADY;
      @(posedge clk);
      if (hs)
        acc = 1'b1;
    end
    #1;
    ARVALID = 1'b0;
    if (acc)
      model_ar(id, a, len, sz, bt);
  endtask

  task automatic wait_rvalid(input int maxc, output int n);
    n = 0;
    while (n < maxc) begin
      @(posedge clk);
      #1;
      n++;
      if (RVALID)
        break;
    end
  endtask

  task automatic wait_drain(input int maxc);
    int k = 0;
    while ((sb.size() != 0 || maq.size() != 0) && k < maxc) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_beats", sb.size(), 0);
    check("drain_mem", maq.size(), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    int n;
    bit seen;

    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", ARREADY, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_rlast", RLAST, 0);
    check("rst_rresp", RRESP, 0);
    check("rst_rid", RID, 0);
    check("rst_rdata", RDATA, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_addr", mem_addr, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("arready_after_rst", ARREADY, 1);

    // INCR burst: latency and beat rate
    rr_val = 1'b1;
    pop_cyc.delete();
    send_ar(4'h3, 32'h10, 8'd3, 3'd2, 2'd1, 4, acc);
    check("incr_accept", acc, 1);
    wait_rvalid(10, n);
    check("incr_latency", n, 3);
    wait_drain(100);
    check("incr_beats", pop_cyc.size(), 4);
    for (int i = 1; i < pop_cyc.size(); i++)
      check("beat_rate", pop_cyc[i] - pop_cyc[i-1], 3);

    // WRAP then FIXED
    send_ar(4'h5, 32'h38, 8'd3, 3'd2, 2'd2, 4, acc);
    check("wrap_accept", acc, 1);
    send_ar(4'h6, 32'h20, 8'd2, 3'd2, 2'd0, 4, acc);
    check("fixed_accept", acc, 1);
    wait_drain(200);

    // Backpressure: engine holds one, queue holds four
    rr_val = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_ar(4'(i + 1), 32'(i * 16), 8'd1, 3'd2, 2'd1, 1, acc);
      check("bp_accept", acc, 1);
    end
    send_ar(4'h7, 32'h80, 8'd1, 3'd2, 2'd1, 8, acc);
    check("bp_sixth_refused", acc, 0);
    check("bp_arready_low", ARREADY, 0);
    repeat (6) @(posedge clk);
    #1;
    rr_val = 1'b1;
    wait_drain(300);

    // Range error mid-burst, reserved burst type
    send_ar(4'h8, 32'h3FC, 8'd1, 3'd2, 2'd1, 4, acc);
    check("oor_accept", acc, 1);
    send_ar(4'h9, 32'h40, 8'd2, 3'd2, 2'd3, 4, acc);
    check("rsvd_accept", acc, 1);
    wait_drain(200);

    // Reset during beat 2 of a 4-beat burst, one AR queued
    rr_val = 1'b0;
    send_ar(4'hA, 32'h100, 8'd3, 3'd2, 2'd1, 4, acc);
    send_ar(4'hB, 32'h200, 8'd0, 3'd2, 2'd1, 4, acc);
    wait_rvalid(20, n);
    rr_val = 1'b1;
    @(posedge clk);
    #1;
    rr_val = 1'b0;
    wait_rvalid(20, n);
    check("beat2_present", RVALID, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    maq.delete();
    check("midrst_rvalid", RVALID, 0);
    check("midrst_arready", ARREADY, 0);
    @(posedge clk);
    #1;
    check("midrst_arready_rise", ARREADY, 1);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      seen = seen | RVALID | mem_re;
    end
    check("midrst_quiet", seen, 0);
    rr_val = 1'b1;
    send_ar(4'hC, 32'h84, 8'd0, 3'd2, 2'd1, 4, acc);
    check("postrst_accept", acc, 1);
    wait_rvalid(10, n);
    check("postrst_latency", n, 3);
    wait_drain(50);

    // Randomized traffic with random RREADY
    rr_rand = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int          r;
      int          t;
      logic [1:0]  bt;
      logic [7:0]  ln;
      logic [2:0]  sz;
      logic [31:0] ad;
      r  = $urandom_range(0, 9);
      sz = 3'($urandom_range(0, 3));
      ln = 8'($urandom_range(0, 5));
      if (r == 0)
        bt = 2'd3;
      else if (r < 4)
        bt = 2'd0;
      else if (r < 7)
        bt = 2'd1;
      else
        bt = 2'd2;
      if (bt == 2'd2) begin
        t  = $urandom_range(0, 4);
        ln = (t == 0) ? 8'd1 : (t == 1) ? 8'd3 :
             (t == 2) ? 8'd7 : (t == 3) ? 8'd15 : 8'd2;
      end
      ad = 32'($urandom_range(0, 1100));
      if (bt == 2'd2 && $urandom_range(0, 3) != 0)
        ad = ad & ~((32'd1 << sz) - 32'd1);
      send_ar(4'($urandom), ad, ln, sz, bt, 300, acc);
      check("rand_accept", acc, 1);
    end
    rr_rand = 1'b0;
    rr_val  = 1'b1;
    wait_drain(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
